sram_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (pcF side) and the data-access requester (aluoutM_addr / mem_wenM side) of the 5-stage MIPS core.
- Data side has priority because it is the older instruction; a burst limiter prevents instruction starvation.
- One transaction is outstanding at a time.
- A watchdog flags a hung memory response.

---
 rtl/sram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between instruction fetch and data access,
// data first with a burst limiter, one transaction outstanding, sticky response watchdog.
`default_nettype none

module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_data_ok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_data_ok,
  output logic              bus_err
);

  localparam logic [3:0]  c_MAX_RUN = 4'(MAX_DATA_RUN);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_ADDR = 3'd1,
    S_I_DATA = 3'd2,
    S_D_ADDR = 3'd3,
    S_D_DATA = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_run_cnt;
  logic [15:0]       r_wd_cnt;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [3:0]        r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_bus_err;

  logic              w_grant_data;
  logic [15:0]       w_wd_next;

  // Data wins unless it has already taken MAX_DATA_RUN grants while a fetch waited.
  assign w_grant_data = data_req && (!inst_req || (r_run_cnt < c_MAX_RUN));
  assign w_wd_next    = r_wd_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_run_cnt   <= 4'd0;
      r_wd_cnt    <= 16'd0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wen   <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!inst_req) begin
            r_run_cnt <= 4'd0;
          end
          if (w_grant_data) begin
            r_state     <= S_D_ADDR;
            r_mem_req   <= 1'b1;
            r_mem_wr    <= data_wr;
            r_mem_wen   <= data_wr ? data_wen : 4'd0;
            r_mem_addr  <= data_addr;
            r_mem_wdata <= data_wdata;
            if (inst_req && (r_run_cnt < c_MAX_RUN)) begin
              r_run_cnt <= r_run_cnt + 4'd1;
            end
          end else if (inst_req) begin
            r_state     <= S_I_ADDR;
            r_mem_req   <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_wen   <= 4'd0;
            r_mem_addr  <= inst_addr;
            r_mem_wdata <= 32'd0;
            r_run_cnt   <= 4'd0;
          end
        end
        S_I_ADDR: begin
          if (mem_addr_ok) begin
            r_state   <= S_I_DATA;
            r_mem_req <= 1'b0;
          end
        end
        S_D_ADDR: begin
          if (mem_addr_ok) begin
            r_state   <= S_D_DATA;
            r_mem_req <= 1'b0;
          end
        end
        S_I_DATA, S_D_DATA: begin
          // The watchdog only flags a hang; the transaction keeps waiting.
          if (mem_data_ok) begin
            r_state  <= S_IDLE;
            r_wd_cnt <= 16'd0;
          end else begin
            if (r_wd_cnt != c_TIMEOUT) begin
              r_wd_cnt <= w_wd_next;
            end
            if (w_wd_next >= c_TIMEOUT) begin
              r_bus_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign inst_data_ok = !rst && (r_state == S_I_DATA) && mem_data_ok;
  assign data_data_ok = !rst && (r_state == S_D_DATA) && mem_data_ok;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign mem_req      = r_mem_req;
  assign mem_wr       = r_mem_wr;
  assign mem_wen      = r_mem_wen;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign bus_err      = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with hand-computed expectations.
`default_nettype none

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(
    .ADDR_W      (32),
    .MAX_DATA_RUN(4),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_data_ok(data_data_ok),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_rdata   (mem_rdata),
    .mem_data_ok (mem_data_ok),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_rdata = 32'd0; mem_data_ok = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_oks", 32'({inst_data_ok, data_data_ok}), 32'd0);
    rst = 1'b0;
    tick();

    // single fetch
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    tick();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'hBFC00000);
    chk("f_mem_wen", 32'(mem_wen), 32'd0);
    chk("f_mem_wr", 32'(mem_wr), 32'd0);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    chk("f_req_once", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'h24010001;
    #1;
    chk("f_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
    chk("f_rdata", inst_rdata, 32'h24010001);
    tick();
    inst_req = 1'b0; mem_data_ok = 1'b0;
    #1;
    chk("f_ok_done", 32'(inst_data_ok), 32'd0);
    tick();
    chk("f_idle", 32'(mem_req), 32'd0);

    // store byte with a 3-cycle addr_ok stall
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0100;
    data_addr = 32'h80000002; data_wdata = 32'hABABABAB;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("st_req%0d", s), 32'(mem_req), 32'd1);
      chk($sformatf("st_wen%0d", s), 32'(mem_wen), 32'b0100);
      chk($sformatf("st_wdata%0d", s), mem_wdata, 32'hABABABAB);
      tick();
    end
    chk("st_wr", 32'(mem_wr), 32'd1);
    chk("st_addr", mem_addr, 32'h80000002);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("st_dataok_in_addr", 32'(data_data_ok), 32'd0);
    tick();
    mem_addr_ok = 1'b0;
    #1;
    chk("st_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
    chk("st_req_low", 32'(mem_req), 32'd0);
    tick();
    data_req = 1'b0; mem_data_ok = 1'b0;
    #1;
    chk("st_ok_done", 32'(data_data_ok), 32'd0);

    // contention: both held, expect D,D,D,D,I,D,D,D,D,I
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b1111; data_addr = 32'h2000;
    for (int g = 0; g < 10; g++) begin
      tick();
      chk($sformatf("grant%0d", g), 32'(mem_addr == 32'h2000), 32'(exp_d[g]));
      chk($sformatf("grant_wen%0d", g), 32'(mem_wen), 32'd0);
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hC0DE0000 | 32'(g);
      #1;
      chk($sformatf("grant_ok%0d", g), 32'({inst_data_ok, data_data_ok}),
          exp_d[g] ? 32'b01 : 32'b10);
      tick();
      mem_data_ok = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // simultaneous arrival: data first, fetch right after
    inst_req = 1'b1; inst_addr = 32'h5000;
    data_req = 1'b1; data_addr = 32'h6000;
    tick();
    chk("sim_first", mem_addr, 32'h6000);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("sim_dok", 32'(data_data_ok), 32'd1);
    tick();
    data_req = 1'b0; mem_data_ok = 1'b0;
    tick();
    chk("sim_second", mem_addr, 32'h5000);
    chk("sim_second_req", 32'(mem_req), 32'd1);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    chk("sim_iok", 32'({inst_data_ok, data_data_ok}), 32'b10);
    chk("sim_irdata", inst_rdata, 32'h0BADF00D);
    tick();
    inst_req = 1'b0; mem_data_ok = 1'b0;

    // watchdog: data_ok never arrives
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h7000;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    chk("wd_start", 32'(bus_err), 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("wd_low%0d", k), 32'(bus_err), 32'd0);
    end
    tick();
    chk("wd_rise", 32'(bus_err), 32'd1);
    repeat (3) tick();
    chk("wd_sticky", 32'(bus_err), 32'd1);
    mem_data_ok = 1'b1;
    #1;
    chk("wd_late_ok", 32'(data_data_ok), 32'd1);
    tick();
    data_req = 1'b0; mem_data_ok = 1'b0;
    chk("wd_after", 32'(bus_err), 32'd1);

    // reset mid-transaction, late response ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_clear", 32'(bus_err), 32'd0);
    inst_req = 1'b1; inst_addr = 32'h3000;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    rst = 1'b1; inst_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rr_no_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rr_req", 32'(mem_req), 32'd0);
    chk("rr_addr", mem_addr, 32'd0);
    chk("rr_wen", 32'({mem_wr, mem_wen}), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h4000;
    tick();
    chk("rr_new_req", 32'(mem_req), 32'd1);
    chk("rr_new_addr", mem_addr, 32'h4000);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11223344;
    #1;
    chk("rr_new_ok", 32'(inst_data_ok), 32'd1);
    chk("rr_new_rdata", inst_rdata, 32'h11223344);
    tick();
    inst_req = 1'b0; mem_data_ok = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
